lcd_bus_receiver: RTL

Synchronous receiver for the 8-bit HD44780-style parallel LCD bus (`en`, `rs`, `rw`, `on`, `lcd_data`) driven by the LCD controller block. It detects write strobes on the falling edge of `en` and decodes command and data bytes. It also maintains a 32-character shadow display (2 lines × 16), a cursor and the display-on state, so benches and on-chip self-checks can read back exactly what the transmitter wrote. It sits on the far end of the LCD pins, in place of the real panel, in simulation and loopback builds.

---
 rtl/lcd_bus_receiver.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_bus_receiver.sv
// lcd_bus_receiver
//
// Far-end receiver for an 8-bit HD44780-style parallel LCD bus. It stands in
// for the panel in simulation and loopback builds. Write strobes are detected
// on the synchronized falling edge of en, then decoded as commands or data
// bytes into a 32-character shadow display (2 x 16) with cursor,
// entry-mode (I/D) and display-on state.
//
// Optional feature: define LCD_RX_ERRCHK_EN to add the sticky err_overrun output.
// The flag is set by any strobe rejected for busy, short en high time,
// rw=1 or on=0.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   en, rs, rw, on      LCD bus control pins (asynchronous to clk)
//   lcd_data[7:0]       LCD bus byte
//   rd_addr[4:0]        shadow-display read index (0-15 line 1, 16-31 line 2)
//   rd_char[7:0]        registered character at rd_addr
//   cmd_valid           one-cycle pulse: command byte accepted
//   data_valid          one-cycle pulse: data byte accepted
//   last_byte[7:0]      last accepted byte
//   cursor[4:0]         current write index
//   display_on          display-control D bit
//   busy                clear-fill in progress
//   err_overrun         sticky rejected-strobe flag (LCD_RX_ERRCHK_EN only)
module lcd_bus_receiver #(
  parameter int unsigned MIN_EN_HIGH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       rs,
  input  logic       rw,
  input  logic       on,
  input  logic [7:0] lcd_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic       cmd_valid,
  output logic       data_valid,
  output logic [7:0] last_byte,
  output logic [4:0] cursor,
  output logic       display_on,
  output logic       busy
`ifdef LCD_RX_ERRCHK_EN
  ,
  output logic       err_overrun
`endif
);

  localparam int unsigned CntW = (MIN_EN_HIGH < 1) ? 1 : $clog2(MIN_EN_HIGH + 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  // Synchronizer stages hold {en, rs, rw, on, lcd_data}.
  logic [11:0]     sync1_q, sync1_d, sync2_q, sync2_d;
  // Capture register holds {rs, rw, on, data} from the last en-high cycle.
  logic [10:0]     cap_q, cap_d;
  logic [CntW-1:0] hi_cnt_q, hi_cnt_d;
  logic [1:0]      settle_q, settle_d;
  logic            armed_q, armed_d;
  logic            en_prev_q, en_prev_d;
  state_e          state_q, state_d;
  logic [4:0]      fill_idx_q, fill_idx_d;
  logic [4:0]      cursor_q, cursor_d;
  logic            id_q, id_d;
  logic            disp_q, disp_d;
  logic [7:0]      last_q, last_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic            data_valid_q, data_valid_d;
  logic [7:0]      rd_char_q, rd_char_d;
  logic [7:0]      mem_q [32];
  logic            mem_we;
  logic [4:0]      mem_waddr;
  logic [7:0]      mem_wdata;
  logic            en_s, settle_done, strobe_fall, strobe_ok;
`ifdef LCD_RX_ERRCHK_EN
  logic            err_q, err_d;
`endif

  assign en_s        = sync2_q[11];
  assign settle_done = (settle_q == 2'd2);
  assign strobe_fall = en_prev_q & ~en_s;
  assign strobe_ok   = strobe_fall & (hi_cnt_q == CntW'(MIN_EN_HIGH)) & cap_q[8] & ~cap_q[9];

  always_comb begin
    sync1_d      = {en, rs, rw, on, lcd_data};
    sync2_d      = sync1_q;
    cap_d        = en_s ? sync2_q[10:0] : cap_q;
    settle_d     = settle_done ? settle_q : settle_q + 2'd1;
    // After reset the synchronizer output is not trusted until it has settled,
    // and a strobe then needs a genuine low-to-high edge on en.
    armed_d      = armed_q | (settle_done & ~en_s);
    en_prev_d    = en_s & armed_q;
    hi_cnt_d     = hi_cnt_q;
    if (!en_s) begin
      hi_cnt_d = '0;
    end else if (armed_q && hi_cnt_q != CntW'(MIN_EN_HIGH)) begin
      hi_cnt_d = hi_cnt_q + CntW'(1);
    end

    state_d      = state_q;
    fill_idx_d   = fill_idx_q;
    cursor_d     = cursor_q;
    id_d         = id_q;
    disp_d       = disp_q;
    last_d       = last_q;
    cmd_valid_d  = 1'b0;
    data_valid_d = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = cursor_q;
    mem_wdata    = cap_q[7:0];
    rd_char_d    = mem_q[rd_addr];

    unique case (state_q)
      StIdle: begin
        if (strobe_ok) begin
          last_d = cap_q[7:0];
          if (cap_q[10]) begin
            mem_we       = 1'b1;
            cursor_d     = id_q ? cursor_q + 5'd1 : cursor_q - 5'd1;
            data_valid_d = 1'b1;
          end else begin
            cmd_valid_d = 1'b1;
            if (cap_q[7]) begin
              // 0x00-0x0F -> 0-15, 0x40-0x4F -> 16-31; other addresses fold the same way.
              cursor_d = {cap_q[6], cap_q[3:0]};
            end else if (cap_q[6] || cap_q[5] || cap_q[4]) begin
              // CGRAM address, function set, shift: accepted, no state change.
            end else if (cap_q[3]) begin
              disp_d = cap_q[2];
            end else if (cap_q[2]) begin
              id_d = cap_q[1];
            end else if (cap_q[1]) begin
              cursor_d = 5'd0;
            end else if (cap_q[0]) begin
              cursor_d   = 5'd0;
              id_d       = 1'b1;
              fill_idx_d = 5'd0;
              state_d    = StClear;
            end
          end
        end
      end
      StClear: begin
        mem_we     = 1'b1;
        mem_waddr  = fill_idx_q;
        mem_wdata  = 8'h20;
        fill_idx_d = fill_idx_q + 5'd1;
        if (fill_idx_q == 5'd31) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef LCD_RX_ERRCHK_EN
    err_d = err_q;
    if (strobe_fall && !(strobe_ok && state_q == StIdle)) begin
      err_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      cap_q        <= '0;
      hi_cnt_q     <= '0;
      settle_q     <= '0;
      armed_q      <= 1'b0;
      en_prev_q    <= 1'b0;
      state_q      <= StIdle;
      fill_idx_q   <= '0;
      cursor_q     <= '0;
      id_q         <= 1'b1;
      disp_q       <= 1'b0;
      last_q       <= '0;
      cmd_valid_q  <= 1'b0;
      data_valid_q <= 1'b0;
      rd_char_q    <= '0;
`ifdef LCD_RX_ERRCHK_EN
      err_q        <= 1'b0;
`endif
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      cap_q        <= cap_d;
      hi_cnt_q     <= hi_cnt_d;
      settle_q     <= settle_d;
      armed_q      <= armed_d;
      en_prev_q    <= en_prev_d;
      state_q      <= state_d;
      fill_idx_q   <= fill_idx_d;
      cursor_q     <= cursor_d;
      id_q         <= id_d;
      disp_q       <= disp_d;
      last_q       <= last_d;
      cmd_valid_q  <= cmd_valid_d;
      data_valid_q <= data_valid_d;
      rd_char_q    <= rd_char_d;
`ifdef LCD_RX_ERRCHK_EN
      err_q        <= err_d;
`endif
    end
  end

  // Shadow display storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign rd_char    = rd_char_q;
  assign cmd_valid  = cmd_valid_q;
  assign data_valid = data_valid_q;
  assign last_byte  = last_q;
  assign cursor     = cursor_q;
  assign display_on = disp_q;
  assign busy       = (state_q == StClear);
`ifdef LCD_RX_ERRCHK_EN
  assign err_overrun = err_q;
`endif

endmodule
